// File: rtl/jg_pkg.sv
// Shared types and the reference verdict function for the judging unit.
// The function is width-generic through an explicit voter count.
package jg_pkg;

  localparam int JG_MAX_N = 64;

  typedef enum logic {
    JG_EMPTY = 1'b0,
    JG_FULL  = 1'b1
  } jg_state_e;

  // Returns {pass, none}; only v[n-1:0] is looked at.
  function automatic logic [1:0] jg_verdict(
    input logic [JG_MAX_N-1:0] v,
    input int                  n,
    input int                  k
  );
    int   c;
    logic any;
    c   = 0;
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      any = any | v[i];
      if (i < n - 1 && v[i]) c++;
    end
    return {v[n-1] && (c >= k), !any};
  endfunction

endpackage

// File: rtl/jg_if.sv
// Vote-in / verdict-out bundle with valid/ready on both sides.
// slave is the judge; master is whoever drives it.
interface jg_if #(
  parameter int N     = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     votes;
  logic             out_valid;
  logic             out_ready;
  logic             pass;
  logic             none;
  logic [CNT_W-1:0] round_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic             clr;

  modport master (
    output in_valid, votes, out_ready, clr,
    input  in_ready, out_valid, pass, none,
    input  round_cnt, pass_cnt
  );

  modport slave (
    input  in_valid, votes, out_ready, clr,
    output in_ready, out_valid, pass, none,
    output round_cnt, pass_cnt
  );
endinterface

// File: rtl/jg_popcount.sv
// Combinational count of set bits in a W-bit vector.
module jg_popcount #(
  parameter int W  = 2,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/jg_judge.sv
// Registered N-voter judge: chief plus quorum of K ordinary voters,
// one-deep output register with valid/ready and saturating tallies.
module jg_judge
  import jg_pkg::*;
#(
  parameter int N     = 3,
  parameter int K     = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  jg_if.slave bus
);

  localparam int PW = N - 1;
  localparam int CW = $clog2(N);

  if (N < 2) begin : g_bad_n
    $error("jg_judge: N must be at least 2");
  end
  if (K < 0 || K > N - 1) begin : g_bad_k
    $error("jg_judge: K must be in 0..N-1");
  end

  jg_state_e        state_q, state_d;
  logic             pass_q, pass_d;
  logic             none_q, none_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  logic [CW-1:0]    pop;
  logic             pass_c;
  logic             none_c;
  logic             full;
  logic             acc;
  logic [CNT_W-1:0] rbase;
  logic [CNT_W-1:0] pbase;

  jg_popcount #(.W(PW), .CW(CW)) u_pop (
    .bits_i (bus.votes[N-2:0]),
    .cnt_o  (pop)
  );

  assign pass_c = bus.votes[N-1] && (int'(pop) >= K);
  assign none_c = (bus.votes == '0);

  assign full         = (state_q == JG_FULL);
  assign bus.in_ready = !full || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;

  // clr only zeroes the base; an accept in the same cycle counts on top.
  assign rbase = bus.clr ? '0 : rcnt_q;
  assign pbase = bus.clr ? '0 : pcnt_q;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    none_d  = none_q;
    rcnt_d  = rbase;
    pcnt_d  = pbase;
    if (acc) begin
      state_d = JG_FULL;
      pass_d  = pass_c;
      none_d  = none_c;
      if (rbase != '1) rcnt_d = rbase + 1'b1;
      if (pass_c && pbase != '1) pcnt_d = pbase + 1'b1;
    end else if (full && bus.out_ready) begin
      state_d = JG_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= JG_EMPTY;
      pass_q  <= 1'b0;
      none_q  <= 1'b0;
      rcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      none_q  <= none_d;
      rcnt_q  <= rcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign bus.out_valid = full;
  assign bus.pass      = pass_q;
  assign bus.none      = none_q;
  assign bus.round_cnt = rcnt_q;
  assign bus.pass_cnt  = pcnt_q;

endmodule
